override_sequencer: RTL and testbench

OVERRIDE_SEQUENCER -- requirements
Module: override_sequencer

---
 rtl/override_pkg.sv | 15 +
 rtl/override_timer.sv | 38 +++
 rtl/override_sequencer.sv | 119 +++++++++++
 tb/tb_override_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/override_pkg.sv
// Shared definitions for the override sequencer.
//   DEF_WIDTH   : default width of the held value
//   DEF_DUR_W   : default width of the override duration field
//   ovr_state_e : sequencer FSM states (IDLE, ACTIVE)
package override_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DUR_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ovr_state_e;

endpackage

// File: rtl/override_timer.sv
// Override duration counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load, len : load the counter with len (load wins over dec)
//   dec       : decrement by one; the count never goes below 1 and never wraps
//   expire    : count == 1, the current cycle is the last timed override cycle
//   infinite  : count == 0, the loaded length was 0 (hold until released)
module override_timer
    import override_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DUR_W-1:0] len,
    input  logic             dec,
    output logic             expire,
    output logic             infinite
);

    logic [DUR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= len;
        end else if (dec && (count > {{(DUR_W-1){1'b0}}, 1'b1})) begin
            // Floor at 1: a count of 0 (hold forever) or 1 (expiring) never moves.
            count <= count - 1'b1;
        end
    end

    assign expire   = (count == {{(DUR_W-1){1'b0}}, 1'b1});
    assign infinite = (count == '0);

endmodule

// File: rtl/override_sequencer.sv
// Holds a value for a downstream register. Normal writes update it in IDLE;
// an accepted override takes ownership of it for ovr_len cycles (or until
// rel_req when ovr_len is 0), during which normal writes are discarded.
//
// Handshake: an override is accepted at a rising edge where ovr_valid and
// ovr_ready are both 1. ovr_ready depends on state only (1 in IDLE), so the
// requester may hold ovr_valid high; each IDLE entry accepts at most once.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en, wr_data      : normal write strobe and value
//   ovr_valid/ovr_ready : override request handshake
//   ovr_data, ovr_len   : override value and duration (0 = until released)
//   rel_req             : early release of an active override
//   q                   : held value (registered)
//   ovr_active          : override owns q (registered)
//   ovr_done            : one-cycle pulse in the first IDLE cycle after release
//   wr_dropped          : one-cycle pulse after a discarded normal write
module override_sequencer
    import override_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ovr_valid,
    output logic             ovr_ready,
    input  logic [WIDTH-1:0] ovr_data,
    input  logic [DUR_W-1:0] ovr_len,
    input  logic             rel_req,
    output logic [WIDTH-1:0] q,
    output logic             ovr_active,
    output logic             ovr_done,
    output logic             wr_dropped
);

    ovr_state_e       state, state_d;
    logic [WIDTH-1:0] q_d;
    logic             active_d;
    logic             done_d;
    logic             dropped_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_expire;
    logic             tmr_infinite;

    assign ovr_ready = (state == IDLE);

    override_timer #(
        .DUR_W (DUR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .len      (ovr_len),
        .dec      (tmr_dec),
        .expire   (tmr_expire),
        .infinite (tmr_infinite)
    );

    always_comb begin
        state_d   = state;
        q_d       = q;
        active_d  = 1'b0;
        done_d    = 1'b0;
        dropped_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        case (state)
            IDLE: begin
                if (ovr_valid) begin
                    // Override beats a same-edge write; the write is reported dropped.
                    state_d   = ACTIVE;
                    q_d       = ovr_data;
                    active_d  = 1'b1;
                    tmr_load  = 1'b1;
                    dropped_d = wr_en;
                end else if (wr_en) begin
                    q_d = wr_data;
                end
            end
            ACTIVE: begin
                // Writes are discarded on every ACTIVE edge, the release edge included.
                dropped_d = wr_en;
                if (rel_req || tmr_expire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    active_d = 1'b1;
                    tmr_dec  = !tmr_infinite;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            ovr_active <= 1'b0;
            ovr_done   <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_d;
            q          <= q_d;
            ovr_active <= active_d;
            ovr_done   <= done_d;
            wr_dropped <= dropped_d;
        end
    end

endmodule

// File: tb/tb_override_sequencer.sv
module tb_override_sequencer;

    localparam int WIDTH = 4;
    localparam int DUR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             ovr_valid = 1'b0;
    logic             ovr_ready;
    logic [WIDTH-1:0] ovr_data = '0;
    logic [DUR_W-1:0] ovr_len = '0;
    logic             rel_req = 1'b0;
    logic [WIDTH-1:0] q;
    logic             ovr_active;
    logic             ovr_done;
    logic             wr_dropped;

    override_sequencer #(
        .WIDTH (WIDTH),
        .DUR_W (DUR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovr_valid  (ovr_valid),
        .ovr_ready  (ovr_ready),
        .ovr_data   (ovr_data),
        .ovr_len    (ovr_len),
        .rel_req    (rel_req),
        .q          (q),
        .ovr_active (ovr_active),
        .ovr_done   (ovr_done),
        .wr_dropped (wr_dropped)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Expected word: {q, ovr_active, ovr_done, wr_dropped, ovr_ready}
    logic [WIDTH+3:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q      = '0;
    logic             m_active = 1'b0;
    int               m_left   = 0;   // remaining active cycles, 0 = until released
    logic             m_done   = 1'b0;
    logic             m_drop   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic we, input logic [WIDTH-1:0] wd,
                        input logic ov, input logic [WIDTH-1:0] od,
                        input logic [DUR_W-1:0] ol, input logic rr);
        logic [WIDTH+3:0] e;
        rst = r; wr_en = we; wr_data = wd;
        ovr_valid = ov; ovr_data = od; ovr_len = ol; rel_req = rr;

        if (r) begin
            m_q = '0; m_active = 1'b0; m_left = 0; m_done = 1'b0; m_drop = 1'b0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (ov) begin
                m_q = od; m_active = 1'b1; m_left = int'(ol); m_drop = we;
            end else begin
                m_drop = 1'b0;
                if (we) m_q = wd;
            end
        end else begin
            m_drop = we;
            if (rr || m_left == 1) begin
                m_active = 1'b0; m_done = 1'b1;
            end else begin
                m_done = 1'b0;
                if (m_left > 1) m_left = m_left - 1;
            end
        end
        exp_q.push_back({m_q, m_active, m_done, m_drop, !m_active});

        @(posedge clk);
        #1;
        cycle++;
        e = exp_q.pop_front();
        check("q",          32'(q),          32'(e[WIDTH+3:4]));
        check("ovr_active", 32'(ovr_active), 32'(e[3]));
        check("ovr_done",   32'(ovr_done),   32'(e[2]));
        check("wr_dropped", 32'(wr_dropped), 32'(e[1]));
        check("ovr_ready",  32'(ovr_ready),  32'(e[0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, 0);
    endtask

    int act_cnt;
    int done_cnt;

    initial begin
        // Reset
        @(posedge clk); #1;
        step(1, 1, 4'hA, 1, 4'h5, 8'd3, 1);
        step(1, 0, '0, 0, '0, '0, 0);

        // Write 6, then override 15 for 5 cycles; q holds 15 after release
        step(0, 1, 4'd6, 0, '0, '0, 0);
        step(0, 0, '0, 1, 4'd15, 8'd5, 0);
        idle(7);

        // Write during 2nd active cycle is dropped; write 10 after release
        step(0, 0, '0, 1, 4'd15, 8'd5, 0);
        step(0, 0, '0, 0, '0, '0, 0);
        step(0, 1, 4'd3, 0, '0, '0, 0);
        idle(4);
        step(0, 1, 4'd10, 0, '0, '0, 0);
        idle(1);

        // Hold-until-release override, release after 6 active cycles
        step(0, 0, '0, 1, 4'd4, 8'd0, 0);
        idle(5);
        step(0, 0, '0, 0, '0, '0, 1);
        idle(2);
        step(0, 0, '0, 0, '0, '0, 1);   // rel_req in IDLE is ignored

        // Simultaneous write and override: override wins, write dropped
        step(0, 1, 4'd9, 1, 4'd2, 8'd1, 0);
        idle(2);

        // Write on the release edge is dropped
        step(0, 0, '0, 1, 4'd7, 8'd2, 0);
        step(0, 0, '0, 0, '0, '0, 0);
        step(0, 1, 4'd1, 0, '0, '0, 0);
        idle(1);

        // Reset during the 3rd cycle of a 10-cycle override: no ovr_done
        step(0, 0, '0, 1, 4'd8, 8'd10, 0);
        idle(2);
        step(1, 0, '0, 0, '0, '0, 0);
        idle(2);

        // ovr_valid held high with length 255
        act_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 0, '0, 1, 4'd12, 8'd255, 0);
            if (ovr_active) act_cnt++;
            if (ovr_done) done_cnt++;
        end
        check("len255_active_cycles", 32'(act_cnt), 32'd255);
        check("len255_done_pulses",   32'(done_cnt), 32'd1);
        step(0, 0, '0, 1, 4'd12, 8'd255, 0);   // second accept on the next IDLE entry
        check("len255_reaccept", 32'(ovr_active), 32'd1);
        step(0, 0, '0, 0, '0, '0, 1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) == 0),
                 WIDTH'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0),
                 WIDTH'($urandom_range(0, 15)),
                 DUR_W'($urandom_range(0, 6)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
